// File: rtl/byte_word_loader_pkg.sv
// Shared definitions for the byte-to-word loader and its word-to-byte serializer peer.
package byte_word_loader_pkg;
  localparam int BYTES_PER_WORD = 4;
  localparam int WORD_W         = 32;
  localparam int IDX_W          = 2;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_WORD - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    WRITE   = 2'd2,
    DONE    = 2'd3
  } state_t;
endpackage

// File: rtl/byte_word_loader_packer.sv
// Little-endian byte lane packer: drops each accepted byte into lane idx and advances idx.
module byte_lane_packer
  import byte_word_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              accept,
  input  logic [7:0]        byte_data,
  output logic [IDX_W-1:0]  idx,
  output logic [WORD_W-1:0] word
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx  <= '0;
      word <= '0;
    end else if (clear) begin
      // Lanes start at zero so a flushed partial word reads 0 in unfilled bytes.
      idx  <= '0;
      word <= '0;
    end else if (accept) begin
      word[{idx, 3'b000} +: 8] <= byte_data;
      idx                      <= idx + 1'b1;
    end
  end

endmodule

// File: rtl/byte_word_loader.sv
// Assembles a byte stream into 32-bit words and writes them to RAM at incrementing addresses.
module byte_word_loader
  import byte_word_loader_pkg::*;
#(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              finish,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [ADDR_W:0]   words_written
);

  localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(DEPTH);

  state_t              state_p0, state_nxt;
  logic                flush_p0, flush_nxt;
  logic [ADDR_W-1:0]   addr_p0;
  logic [ADDR_W:0]     words_p0;
  logic                overflow_p0;
  logic                accept;
  logic                session_start;
  logic                last_word;
  logic                pack_clear;
  logic [IDX_W-1:0]    idx;
  logic [WORD_W-1:0]   word;

  assign accept        = byte_valid && (state_p0 == COLLECT);
  assign session_start = start && ((state_p0 == IDLE) || (state_p0 == DONE));
  assign last_word     = (words_p0 + 1'b1) == DEPTH_CNT;
  assign pack_clear    = session_start || (state_p0 == WRITE);

  byte_lane_packer u_packer (
    .clk       (clk),
    .rst       (rst),
    .clear     (pack_clear),
    .accept    (accept),
    .byte_data (byte_data),
    .idx       (idx),
    .word      (word)
  );

  always_comb begin
    state_nxt = state_p0;
    flush_nxt = flush_p0;
    unique case (state_p0)
      IDLE: begin
        if (start) begin
          state_nxt = COLLECT;
          flush_nxt = 1'b0;
        end
      end
      COLLECT: begin
        // A byte arriving with finish is stored first, so it alone can justify a flush write.
        if (byte_valid && (idx == LAST_IDX)) begin
          state_nxt = WRITE;
          flush_nxt = finish;
        end else if (finish) begin
          if ((idx != '0) || byte_valid) begin
            state_nxt = WRITE;
            flush_nxt = 1'b1;
          end else begin
            state_nxt = DONE;
          end
        end
      end
      WRITE: begin
        flush_nxt = 1'b0;
        if (last_word || flush_p0 || finish) state_nxt = DONE;
        else                                 state_nxt = COLLECT;
      end
      DONE: begin
        if (start) begin
          state_nxt = COLLECT;
          flush_nxt = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_p0    <= IDLE;
      flush_p0    <= 1'b0;
      addr_p0     <= '0;
      words_p0    <= '0;
      overflow_p0 <= 1'b0;
    end else begin
      state_p0 <= state_nxt;
      flush_p0 <= flush_nxt;
      if (session_start) begin
        addr_p0     <= '0;
        words_p0    <= '0;
        overflow_p0 <= 1'b0;
      end else begin
        // Address holds at the last slot instead of wrapping once capacity is reached.
        if (state_p0 == WRITE) begin
          words_p0 <= words_p0 + 1'b1;
          if (!last_word) addr_p0 <= addr_p0 + 1'b1;
        end
        if ((state_p0 == DONE) && byte_valid) overflow_p0 <= 1'b1;
      end
    end
  end

  assign byte_ready    = (state_p0 == COLLECT);
  assign busy          = (state_p0 == COLLECT) || (state_p0 == WRITE);
  assign done          = (state_p0 == DONE);
  assign mem_we        = (state_p0 == WRITE);
  assign mem_addr      = addr_p0;
  assign mem_wdata     = word;
  assign overflow      = overflow_p0;
  assign words_written = words_p0;

endmodule

// File: tb/tb_byte_word_loader.sv
// Self-checking bench for byte_word_loader: directed vectors, corner sequences, random sessions.
module tb_byte_word_loader;
  localparam int DEPTH  = 32;
  localparam int ADDR_W = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              finish;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              busy;
  logic              done;
  logic              overflow;
  logic [ADDR_W:0]   words_written;

  byte_word_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .start(start), .finish(finish),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .overflow(overflow), .words_written(words_written)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          timeouts = 0;
  int          accepted = 0;
  int          ready_in_write = 0;
  int          wa_q[$];
  logic [31:0] wd_q[$];

  // Write capture and handshake observation, sampled mid-cycle.
  always @(negedge clk) begin
    if (mem_we) begin
      wa_q.push_back(int'(mem_addr));
      wd_q.push_back(mem_wdata);
      if (byte_ready) ready_in_write++;
    end
    if (byte_valid && byte_ready) accepted++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit ok;
    ok = 1'b0;
    byte_valid = 1'b1;
    byte_data  = b;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (byte_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) timeouts++;
    tick();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_finish();
    finish = 1'b1;
    tick();
    finish = 1'b0;
  endtask

  task automatic wait_done(input string name);
    for (int k = 0; k < 20 && !done; k++) tick();
    check(name, done, 1);
  endtask

  task automatic clear_log();
    wa_q.delete();
    wd_q.delete();
  endtask

  typedef struct {
    int          n;
    logic [7:0]  b0, b1, b2, b3;
    int          exp_writes;
    logic [31:0] exp_word;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic [7:0]  bb[4];
    logic [7:0]  bq[$];
    logic [31:0] w;
    int          n, nw, gap;

    vecs[0] = '{n:0, b0:8'h00, b1:8'h00, b2:8'h00, b3:8'h00, exp_writes:0, exp_word:32'h0};
    vecs[1] = '{n:1, b0:8'hAA, b1:8'h00, b2:8'h00, b3:8'h00, exp_writes:1, exp_word:32'h000000AA};
    vecs[2] = '{n:2, b0:8'hAA, b1:8'hBB, b2:8'h00, b3:8'h00, exp_writes:1, exp_word:32'h0000BBAA};
    vecs[3] = '{n:3, b0:8'h12, b1:8'h34, b2:8'h56, b3:8'h00, exp_writes:1, exp_word:32'h00563412};
    vecs[4] = '{n:4, b0:8'hDE, b1:8'hAD, b2:8'hBE, b3:8'hEF, exp_writes:1, exp_word:32'hEFBEADDE};

    rst = 1'b1; start = 1'b0; finish = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    check("rst_ready", byte_ready, 0);
    check("rst_we", mem_we, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ovf", overflow, 0);
    check("rst_words", words_written, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_addr", mem_addr, 0);

    // Full word
    clear_log();
    pulse_start();
    check("fw_busy", busy, 1);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    byte_valid = 1'b0;
    check("fw_we_latency", mem_we, 1);
    check("fw_ready_in_write", byte_ready, 0);
    tick();
    check("fw_nwrites", wa_q.size(), 1);
    if (wa_q.size() >= 1) begin
      check("fw_addr", wa_q[0], 0);
      check("fw_data", wd_q[0], 32'h44332211);
    end
    check("fw_collect_ready", byte_ready, 1);
    check("fw_words", words_written, 1);
    pulse_finish();
    wait_done("fw_done");

    // Backpressure: valid held high through both WRITE cycles
    clear_log();
    accepted = 0;
    ready_in_write = 0;
    pulse_start();
    for (int i = 0; i < 8; i++) send_byte(8'(i + 1));
    byte_valid = 1'b0;
    tick();
    check("bp_accepted", accepted, 8);
    check("bp_ready_in_write", ready_in_write, 0);
    check("bp_nwrites", wa_q.size(), 2);
    if (wa_q.size() >= 2) begin
      check("bp_addr0", wa_q[0], 0);
      check("bp_data0", wd_q[0], 32'h04030201);
      check("bp_addr1", wa_q[1], 1);
      check("bp_data1", wd_q[1], 32'h08070605);
    end
    pulse_finish();
    wait_done("bp_done");

    // Table: 0..4 bytes then finish
    foreach (vecs[v]) begin
      clear_log();
      bb[0] = vecs[v].b0; bb[1] = vecs[v].b1; bb[2] = vecs[v].b2; bb[3] = vecs[v].b3;
      pulse_start();
      for (int k = 0; k < vecs[v].n; k++) send_byte(bb[k]);
      byte_valid = 1'b0;
      pulse_finish();
      wait_done($sformatf("tbl%0d_done", v));
      check($sformatf("tbl%0d_nwrites", v), wa_q.size(), vecs[v].exp_writes);
      check($sformatf("tbl%0d_words", v), words_written, vecs[v].exp_writes);
      if (vecs[v].exp_writes == 1 && wa_q.size() == 1) begin
        check($sformatf("tbl%0d_addr", v), wa_q[0], 0);
        check($sformatf("tbl%0d_data", v), wd_q[0], vecs[v].exp_word);
      end
    end

    // Capacity and overflow
    clear_log();
    pulse_start();
    for (int i = 0; i < 4 * DEPTH; i++) send_byte(8'(i) ^ 8'h5A);
    byte_valid = 1'b0;
    tick();
    check("cap_done", done, 1);
    check("cap_busy", busy, 0);
    check("cap_words", words_written, DEPTH);
    check("cap_ovf_before", overflow, 0);
    check("cap_nwrites", wa_q.size(), DEPTH);
    for (int wi = 0; wi < DEPTH && wi < wa_q.size(); wi++) begin
      w = 32'h0;
      for (int j = 0; j < 4; j++) w = w | (32'(8'(4 * wi + j) ^ 8'h5A) << (8 * j));
      check($sformatf("cap_addr%0d", wi), wa_q[wi], wi);
      check($sformatf("cap_data%0d", wi), wd_q[wi], w);
    end
    byte_valid = 1'b1;
    byte_data  = 8'hFF;
    tick();
    byte_valid = 1'b0;
    check("cap_ovf", overflow, 1);
    check("cap_no_extra_write", wa_q.size(), DEPTH);
    tick();
    check("cap_ovf_sticky", overflow, 1);
    pulse_start();
    check("cap_restart_ovf", overflow, 0);
    check("cap_restart_done", done, 0);
    check("cap_restart_words", words_written, 0);
    pulse_finish();
    wait_done("cap_end_done");

    // Reset mid-word
    clear_log();
    pulse_start();
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
    byte_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("mrst_we", mem_we, 0);
    check("mrst_busy", busy, 0);
    check("mrst_ready", byte_ready, 0);
    check("mrst_wdata", mem_wdata, 0);
    check("mrst_done", done, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    check("mrst_nwrites", wa_q.size(), 0);
    pulse_start();
    send_byte(8'hA1); send_byte(8'hA2); send_byte(8'hA3); send_byte(8'hA4);
    byte_valid = 1'b0;
    tick();
    check("mrst_after_nwrites", wa_q.size(), 1);
    if (wa_q.size() == 1) begin
      check("mrst_after_addr", wa_q[0], 0);
      check("mrst_after_data", wd_q[0], 32'hA4A3A2A1);
    end
    pulse_finish();
    wait_done("mrst_done_end");

    // finish together with the 4th byte
    clear_log();
    pulse_start();
    send_byte(8'hC1); send_byte(8'hC2); send_byte(8'hC3);
    byte_data  = 8'hC4;
    finish     = 1'b1;
    tick();
    byte_valid = 1'b0;
    finish     = 1'b0;
    check("col4_we", mem_we, 1);
    tick();
    check("col4_done", done, 1);
    repeat (3) tick();
    check("col4_nwrites", wa_q.size(), 1);
    check("col4_words", words_written, 1);
    if (wa_q.size() == 1) check("col4_data", wd_q[0], 32'hC4C3C2C1);

    // finish during WRITE
    clear_log();
    pulse_start();
    send_byte(8'hD1); send_byte(8'hD2); send_byte(8'hD3); send_byte(8'hD4);
    byte_valid = 1'b0;
    check("colw_in_write", mem_we, 1);
    pulse_finish();
    check("colw_done", done, 1);
    check("colw_nwrites", wa_q.size(), 1);
    check("colw_words", words_written, 1);

    // start and finish together in DONE: start wins; start while busy ignored
    start = 1'b1; finish = 1'b1;
    tick();
    start = 1'b0; finish = 1'b0;
    check("sf_busy", busy, 1);
    check("sf_done", done, 0);
    send_byte(8'h77);
    byte_valid = 1'b0;
    pulse_start();
    send_byte(8'h88);
    byte_valid = 1'b0;
    clear_log();
    pulse_finish();
    wait_done("sb_done");
    check("sb_nwrites", wa_q.size(), 1);
    if (wa_q.size() == 1) check("sb_data", wd_q[0], 32'h00008877);

    // Random sessions against a chunk-and-pad reference
    for (int it = 0; it < 16; it++) begin
      clear_log();
      bq.delete();
      n = $urandom_range(0, 40);
      pulse_start();
      for (int i = 0; i < n; i++) begin
        bq.push_back(8'($urandom));
        send_byte(bq[i]);
        byte_valid = 1'b0;
        gap = $urandom_range(0, 2);
        repeat (gap) tick();
      end
      pulse_finish();
      wait_done($sformatf("rnd%0d_done", it));
      nw = (n + 3) / 4;
      check($sformatf("rnd%0d_nwrites", it), wa_q.size(), nw);
      check($sformatf("rnd%0d_words", it), words_written, nw);
      for (int wi = 0; wi < nw && wi < wa_q.size(); wi++) begin
        w = 32'h0;
        for (int j = 0; j < 4; j++)
          if (4 * wi + j < n) w = w | (32'(bq[4 * wi + j]) << (8 * j));
        check($sformatf("rnd%0d_addr%0d", it, wi), wa_q[wi], wi);
        check($sformatf("rnd%0d_data%0d", it, wi), wd_q[wi], w);
      end
    end

    check("handshake_timeouts", timeouts, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
